grf_scoreboard: RTL and testbench

General register file for the five-stage pipeline, sitting opposite the writeback stage: it consumes the writeback port (enable, 5-bit address, 32-bit data, PC) and serves the decode stage's two read ports. It also keeps a per-register in-flight write scoreboard so that decode can stall on unresolved producers. It emits a registered commit trace for the testbench.

---
 rtl/grf_scoreboard.sv | 117 +++++++++++
 tb/tb_grf_scoreboard.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// General register file with per-register in-flight write scoreboard and registered commit trace.
// Optional GRF_BYPASS_EN: same-cycle writeback commit is forwarded to the read ports.
module grf_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_adr,
  input  logic [4:0]  rt_adr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        w_enable,
  input  logic [4:0]  w_adr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        issue_en,
  input  logic [4:0]  issue_adr,
  input  logic        flush,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        sb_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_adr,
  output logic [31:0] trace_data
);

  logic [31:0]      regs    [1:NREG-1];
  logic [CNT_W-1:0] cnt     [1:NREG-1];
  logic [CNT_W-1:0] cnt_nxt [1:NREG-1];
  logic             err_set;
  logic             w_hit;
  logic             iss_hit;
  logic             rs_ok;
  logic             rt_ok;

  assign w_hit   = w_enable && (w_adr != '0) && (32'(w_adr) < NREG);
  assign iss_hit = issue_en && (issue_adr != '0) && (32'(issue_adr) < NREG);
  assign rs_ok   = (rs_adr != '0) && (32'(rs_adr) < NREG);
  assign rt_ok   = (rt_adr != '0) && (32'(rt_adr) < NREG);

  // A matching issue and retire cancel; flush overrides both and raises no error.
  always_comb begin
    err_set = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (flush) begin
        cnt_nxt[i] = '0;
      end else if (iss_hit && (issue_adr == 5'(i)) && !(w_hit && (w_adr == 5'(i)))) begin
        if (cnt[i] == '1) err_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (w_hit && (w_adr == 5'(i)) && !(iss_hit && (issue_adr == 5'(i)))) begin
        if (cnt[i] == '0) err_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err      <= 1'b0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_adr   <= '0;
      trace_data  <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (w_hit) regs[w_adr] <= w_data;
      if (err_set) sb_err <= 1'b1;
      trace_valid <= w_hit;
      if (w_hit) begin
        trace_pc   <= w_pc;
        trace_adr  <= w_adr;
        trace_data <= w_data;
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (rs_ok) begin
      rs_data = regs[rs_adr];
      rs_busy = (cnt[rs_adr] != '0);
`ifdef GRF_BYPASS_EN
      // The committing write retires the last producer, so decode need not wait.
      if (w_hit && (w_adr == rs_adr)) begin
        rs_data = w_data;
        if (cnt[rs_adr] == CNT_W'(1)) rs_busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rt_data = '0;
    rt_busy = 1'b0;
    if (rt_ok) begin
      rt_data = regs[rt_adr];
      rt_busy = (cnt[rt_adr] != '0);
`ifdef GRF_BYPASS_EN
      if (w_hit && (w_adr == rt_adr)) begin
        rt_data = w_data;
        if (cnt[rt_adr] == CNT_W'(1)) rt_busy = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_grf_scoreboard;

  localparam int RSD = 0, RTD = 1, RSB = 2, RTB = 3, ERR = 4, TV = 5, TPC = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_adr, rt_adr, w_adr, issue_adr;
  logic [31:0] rs_data, rt_data, w_data, w_pc;
  logic        w_enable, issue_en, flush;
  logic        rs_busy, rt_busy, sb_err, trace_valid;
  logic [31:0] trace_pc, trace_data;
  logic [4:0]  trace_adr;

  int tests  = 0;
  int failed = 0;

  int          kind_q [$];
  logic [31:0] exp_q  [$];
  string       name_q [$];
  logic [31:0] tpc_q [$];
  logic [4:0]  tadr_q [$];
  logic [31:0] tdat_q [$];

  grf_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .rs_adr(rs_adr), .rt_adr(rt_adr), .rs_data(rs_data), .rt_data(rt_data),
    .w_enable(w_enable), .w_adr(w_adr), .w_data(w_data), .w_pc(w_pc),
    .issue_en(issue_en), .issue_adr(issue_adr), .flush(flush),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .sb_err(sb_err),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_adr(trace_adr), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Monitor: drains queued probes and checks every presented trace record.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      int          k;
      logic [31:0] e, a;
      string       n;
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (k)
        RSD:     a = rs_data;
        RTD:     a = rt_data;
        RSB:     a = {31'd0, rs_busy};
        RTB:     a = {31'd0, rt_busy};
        ERR:     a = {31'd0, sb_err};
        TV:      a = {31'd0, trace_valid};
        default: a = trace_pc;
      endcase
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL %s: got 0x%08h, required 0x%08h", n, a, e);
      end
    end
    if (trace_valid === 1'b1) begin
      tests++;
      if (tpc_q.size() == 0) begin
        failed++;
        $display("FAIL trace_unexpected: got pc 0x%08h adr %0d, required no record", trace_pc, trace_adr);
      end else begin
        logic [31:0] ep, ed;
        logic [4:0]  ea;
        ep = tpc_q.pop_front();
        ea = tadr_q.pop_front();
        ed = tdat_q.pop_front();
        if (trace_pc !== ep || trace_adr !== ea || trace_data !== ed) begin
          failed++;
          $display("FAIL trace_record: got pc 0x%08h adr %0d data 0x%08h, required pc 0x%08h adr %0d data 0x%08h",
                   trace_pc, trace_adr, trace_data, ep, ea, ed);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_enable = 1'b0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    w_enable = 1'b1;
    w_adr    = a;
    w_data   = d;
    w_pc     = pc;
    if (a != 5'd0) begin
      tpc_q.push_back(pc);
      tadr_q.push_back(a);
      tdat_q.push_back(d);
    end
  endtask

  task automatic issue(input logic [4:0] a);
    issue_en  = 1'b1;
    issue_adr = a;
  endtask

  logic [31:0] byp_data;
  logic [31:0] byp_busy;

  initial begin
`ifdef GRF_BYPASS_EN
    byp_data = 32'h0000CAFE;
    byp_busy = 32'd0;
`else
    byp_data = 32'd0;
    byp_busy = 32'd1;
`endif
    reset = 1'b0;
    rs_adr = '0; rt_adr = '0; w_adr = '0; issue_adr = '0;
    w_data = '0; w_pc = '0;
    idle();
    cyc(); cyc();
    reset = 1'b1;

    // Asynchronous reset mid-operation
    commit(5'd5, 32'h1234, 32'h100);
    cyc(); idle(); rs_adr = 5'd5;
    probe(RSD, 32'h1234, "pre_reset_read");
    cyc();
    reset = 1'b0;
    probe(RSD, 32'd0, "rst_rs_data");
    probe(ERR, 32'd0, "rst_sb_err");
    probe(TV,  32'd0, "rst_trace_valid");
    cyc(); cyc();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs_adr = 5'(i);
      rt_adr = 5'(31 - i);
      probe(RSD, 32'd0, "post_rst_rs_data");
      probe(RTD, 32'd0, "post_rst_rt_data");
      probe(RSB, 32'd0, "post_rst_rs_busy");
      cyc();
    end

    // $0 write, issue and retire are ignored
    commit(5'd0, 32'hFFFFFFFF, 32'h200);
    issue(5'd0);
    rs_adr = 5'd0;
    cyc(); idle();
    probe(RSD, 32'd0, "r0_data");
    probe(RSB, 32'd0, "r0_busy");
    probe(TV,  32'd0, "r0_trace_valid");
    probe(ERR, 32'd0, "r0_no_err");
    cyc();

    // Underflow
    commit(5'd20, 32'h20, 32'h204);
    cyc(); idle(); rs_adr = 5'd20;
    probe(ERR, 32'd1, "underflow_err");
    probe(RSB, 32'd0, "underflow_hold0");
    probe(RSD, 32'h20, "underflow_write");
    cyc();
    probe(ERR, 32'd1, "err_sticky");
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    probe(ERR, 32'd0, "err_cleared_by_reset");
    cyc();

    // Counting to max, overflow, then drain
    rs_adr = 5'd8;
    for (int k = 0; k < 3; k++) begin
      issue(5'd8);
      cyc(); idle();
      probe(RSB, 32'd1, "count_busy");
      probe(ERR, 32'd0, "count_at_max_ok");
      cyc();
    end
    issue(5'd8);
    cyc(); idle();
    probe(RSB, 32'd1, "overflow_busy");
    probe(ERR, 32'd1, "overflow_err");
    cyc();
    for (int k = 0; k < 3; k++) begin
      commit(5'd8, 32'h80 + 32'(k), 32'h1000 + 32'(4 * k));
      cyc(); idle();
      probe(RSB, (k < 2) ? 32'd1 : 32'd0, "drain_busy");
      probe(RSD, 32'h80 + 32'(k), "drain_data");
      cyc();
    end

    // Same-cycle issue/retire, then flush
    issue(5'd9);
    cyc(); idle(); cyc();
    issue(5'd9);
    commit(5'd9, 32'h99, 32'h2000);
    cyc(); idle(); rs_adr = 5'd9;
    probe(RSB, 32'd1, "iss_ret_same_busy");
    probe(RSD, 32'h99, "iss_ret_same_data");
    cyc();
    issue(5'd9);
    commit(5'd9, 32'hAA, 32'h2004);
    flush = 1'b1;
    cyc(); idle();
    probe(RSB, 32'd0, "flush_clears_count");
    probe(RSD, 32'hAA, "flush_array_writes");
    probe(ERR, 32'd1, "flush_keeps_err");
    cyc();

    // Issue and retire on different registers
    issue(5'd11);
    cyc(); idle(); cyc();
    issue(5'd12);
    commit(5'd11, 32'hB1, 32'h2008);
    cyc(); idle(); rs_adr = 5'd11; rt_adr = 5'd12;
    probe(RSB, 32'd0, "indep_retire");
    probe(RTB, 32'd1, "indep_issue");
    probe(RSD, 32'hB1, "indep_data");
    cyc();

    // Same-cycle bypass
    issue(5'd3);
    cyc(); idle(); rs_adr = 5'd3; rt_adr = 5'd3;
    probe(RSB, 32'd1, "byp_pre_busy");
    cyc();
    commit(5'd3, 32'hCAFE, 32'h3000);
    probe(RSD, byp_data, "byp_rs_data");
    probe(RTD, byp_data, "byp_rt_data");
    probe(RSB, byp_busy, "byp_rs_busy");
    cyc(); idle();
    probe(RSD, 32'hCAFE, "byp_after_edge");
    probe(RSB, 32'd0, "byp_after_busy");
    cyc();

    // Trace record lasts exactly one cycle and then holds
    commit(5'd31, 32'h300C, 32'h3004);
    probe(TV, 32'd0, "trace_pre");
    cyc(); idle();
    probe(TV, 32'd1, "trace_valid");
    cyc();
    probe(TV,  32'd0, "trace_one_cycle");
    probe(TPC, 32'h3004, "trace_hold_pc");
    cyc(); cyc();

    tests++;
    if (tpc_q.size() != 0) begin
      failed++;
      $display("FAIL trace_missing: got %0d records unseen, required 0", tpc_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
